// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int ERR_MODE_STICKY_PTR = 0;
  localparam int ERR_MODE_STICKY     = 1;
  localparam int ERR_MODE_DYNAMIC    = 2;

  localparam int RST_MODE_CLEAR = 0;
  localparam int RST_MODE_KEEP  = 2;

  // Bits needed to hold a count in the range 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_s1_sf_ctl.sv
// FIFO control: read/write pointers, occupancy count, static flags and error tracking.
module fifo_s1_sf_ctl
  import fifo_pkg::*;
#(
  parameter int depth    = 4,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = 0,
  parameter int aw       = $clog2(depth)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_req_n,
  input  logic          pop_req_n,
  input  logic          diag_n,
  output logic          we,
  output logic [aw-1:0] wr_ptr,
  output logic [aw-1:0] rd_ptr,
  output logic          empty,
  output logic          almost_empty,
  output logic          half_full,
  output logic          almost_full,
  output logic          full,
  output logic          error
);

  localparam int CW = count_width(depth);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [CW-1:0] count;
  logic [CW-1:0] count_mod;
  logic [aw:0]   ptr_diff;
  logic          push, pop, do_push, do_pop;
  logic          overflow, underflow, ptr_err, err_q;

  assign push = ~push_req_n;
  assign pop  = ~pop_req_n;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= CW'(ae_level));
  assign half_full    = (count >= CW'((depth + 1) / 2));
  assign almost_full  = (count >= CW'(depth - af_level));

  // A pop against a full FIFO frees the slot the simultaneous push lands in.
  assign do_push   = push & (~full | pop);
  assign do_pop    = pop & ~empty;
  assign overflow  = push & full & ~pop;
  assign underflow = pop & empty;
  assign we        = do_push;

  function automatic logic [aw-1:0] ptr_inc(input logic [aw-1:0] p);
    return (p == aw'(depth - 1)) ? '0 : p + aw'(1);
  endfunction

  // Pointer distance modulo depth must always agree with the count modulo depth.
  always_comb begin
    // NOTE: every variable gets a default before any condition, so no latch is inferred.
    ptr_diff  = {1'b0, wr_ptr} - {1'b0, rd_ptr};
    count_mod = full ? '0 : count;
    if (wr_ptr < rd_ptr) ptr_diff = ptr_diff + (aw + 1)'(depth);
    ptr_err = (err_mode == ERR_MODE_STICKY_PTR) && (ptr_diff != (aw + 1)'(count_mod));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);

      if (err_mode == ERR_MODE_STICKY_PTR && !diag_n) rd_ptr <= '0;
      else if (do_pop)                                rd_ptr <= ptr_inc(rd_ptr);

      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (err_mode == ERR_MODE_DYNAMIC) err_q <= overflow | underflow;
      else                              err_q <= err_q | overflow | underflow | ptr_err;
    end
  end

  assign error = err_q | ptr_err;

endmodule

// File: rtl/fifo_s1_sf.sv
// Single-clock first-word-fall-through FIFO: storage array and read mux around fifo_s1_sf_ctl.
module fifo_s1_sf
  import fifo_pkg::*;
#(
  parameter int width    = 8,
  parameter int depth    = 4,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = 0,
  parameter int rst_mode = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_req_n,
  input  logic             pop_req_n,
  input  logic             diag_n,
  input  logic [width-1:0] data_in,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic             error,
  output logic [width-1:0] data_out
);

  localparam int AW = $clog2(depth);

  logic             we;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [width-1:0] mem [depth];

  if (rst_mode != RST_MODE_CLEAR && rst_mode != RST_MODE_KEEP) begin : g_bad_rst_mode
    $error("fifo_s1_sf: rst_mode must be 0 or 2");
  end

  fifo_s1_sf_ctl #(
    .depth    (depth),
    .ae_level (ae_level),
    .af_level (af_level),
    .err_mode (err_mode),
    .aw       (AW)
  ) u_ctl (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_req_n   (push_req_n),
    .pop_req_n    (pop_req_n),
    .diag_n       (diag_n),
    .we           (we),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .half_full    (half_full),
    .almost_full  (almost_full),
    .full         (full),
    .error        (error)
  );

  if (rst_mode == RST_MODE_CLEAR) begin : g_mem_clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: clearing the array on reset is optional; rst_mode 2 drops it so plain RAM can be used.
        for (int i = 0; i < depth; i++) mem[i] <= '0;
      end else if (we) begin
        mem[wr_ptr] <= data_in;
      end
    end
  end else begin : g_mem_keep
    always_ff @(posedge clk) begin
      if (we) mem[wr_ptr] <= data_in;
    end
  end

  assign data_out = mem[rd_ptr];

endmodule

// File: tb/tb_fifo_s1_sf.sv
// Directed bench for fifo_s1_sf: three instances (sticky+ptr check, non-sticky, depth 3) on shared stimulus.
module tb_fifo_s1_sf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push_req_n = 1'b1;
  logic       pop_req_n = 1'b1;
  logic       diag_n = 1'b1;
  logic [7:0] data_in = 8'h00;

  // flags packed as {empty, almost_empty, half_full, almost_full, full, error}
  logic [5:0] fl_a, fl_b, fl_c;
  logic [7:0] do_a, do_b, do_c;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fifo_s1_sf #(.width(8), .depth(4), .ae_level(1), .af_level(3), .err_mode(0), .rst_mode(0)) u_a (
    .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n), .diag_n(diag_n),
    .data_in(data_in), .empty(fl_a[5]), .almost_empty(fl_a[4]), .half_full(fl_a[3]),
    .almost_full(fl_a[2]), .full(fl_a[1]), .error(fl_a[0]), .data_out(do_a));

  fifo_s1_sf #(.width(8), .depth(4), .ae_level(1), .af_level(3), .err_mode(2), .rst_mode(0)) u_b (
    .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n), .diag_n(diag_n),
    .data_in(data_in), .empty(fl_b[5]), .almost_empty(fl_b[4]), .half_full(fl_b[3]),
    .almost_full(fl_b[2]), .full(fl_b[1]), .error(fl_b[0]), .data_out(do_b));

  fifo_s1_sf #(.width(8), .depth(3), .ae_level(1), .af_level(1), .err_mode(1), .rst_mode(2)) u_c (
    .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n), .diag_n(diag_n),
    .data_in(data_in), .empty(fl_c[5]), .almost_empty(fl_c[4]), .half_full(fl_c[3]),
    .almost_full(fl_c[2]), .full(fl_c[1]), .error(fl_c[0]), .data_out(do_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given requests; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input bit push, input bit pop, input logic [7:0] d);
    push_req_n = ~push;
    pop_req_n  = ~pop;
    data_in    = d;
    @(posedge clk);
    #1;
    push_req_n = 1'b1;
    pop_req_n  = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  logic [7:0] fill_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [5:0] fill_flags [4] = '{6'b010100, 6'b001100, 6'b001100, 6'b001110};
  logic [1:0] wrap_ops [10] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b10, 2'b01};
  logic [7:0] model_q [$];

  initial begin
    // Reset state, asynchronous: visible before any clock edge.
    #2;
    check("reset_flags", 32'(fl_a), 32'(6'b110000));
    check("reset_data",  32'(do_a), 32'h0);
    #10;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'hAA);
    check("idle_after_release_flags", 32'(fl_a), 32'(6'b110000));

    // Fill: flags per count 1..4, head stays first word.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, fill_data[i]);
      check($sformatf("fill%0d_flags", i + 1), 32'(fl_a), 32'(fill_flags[i]));
      check($sformatf("fill%0d_head", i + 1),  32'(do_a), 32'h11);
    end

    // Overflow: rejected push, sticky error; non-sticky instance errors for one cycle.
    cycle(1'b1, 1'b0, 8'h55);
    check("ovf_flags", 32'(fl_a), 32'(6'b001111));
    check("ovf_head",  32'(do_a), 32'h11);
    check("ovf_err_b", 32'(fl_b[0]), 32'h1);

    // Drain in order.
    cycle(1'b0, 1'b1, 8'h00);
    check("pop1_data",    32'(do_a), 32'h22);
    check("pop1_err_b",   32'(fl_b[0]), 32'h0);
    check("pop1_sticky",  32'(fl_a[0]), 32'h1);
    cycle(1'b0, 1'b1, 8'h00);
    check("pop2_data", 32'(do_a), 32'h33);
    cycle(1'b0, 1'b1, 8'h00);
    check("pop3_data", 32'(do_a), 32'h44);
    cycle(1'b0, 1'b1, 8'h00);
    check("pop4_flags", 32'(fl_a), 32'(6'b110001));

    // Underflow on an empty FIFO.
    apply_reset();
    cycle(1'b0, 1'b1, 8'h00);
    check("unf_flags",   32'(fl_a), 32'(6'b110001));
    check("unf_err_b",   32'(fl_b[0]), 32'h1);
    cycle(1'b0, 1'b0, 8'h00);
    check("unf_clear_b", 32'(fl_b[0]), 32'h0);
    check("unf_sticky",  32'(fl_a[0]), 32'h1);

    // Push+pop while full: head advances, no error.
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hA1 + 8'(i));
    cycle(1'b1, 1'b1, 8'hB5);
    check("full_pp_flags", 32'(fl_a), 32'(6'b001110));
    check("full_pp_head",  32'(do_a), 32'hA2);
    cycle(1'b0, 1'b1, 8'h00);
    check("full_pp_pop1", 32'(do_a), 32'hA3);
    cycle(1'b0, 1'b1, 8'h00);
    check("full_pp_pop2", 32'(do_a), 32'hA4);
    cycle(1'b0, 1'b1, 8'h00);
    check("full_pp_pop3", 32'(do_a), 32'hB5);
    cycle(1'b0, 1'b1, 8'h00);
    check("full_pp_empty", 32'(fl_a), 32'(6'b110000));

    // Push+pop while empty: push lands, underflow flagged.
    cycle(1'b1, 1'b1, 8'hC6);
    check("empty_pp_flags", 32'(fl_a), 32'(6'b010101));
    check("empty_pp_data",  32'(do_a), 32'hC6);

    // Wrap-around on the depth-3 instance against a queue model.
    apply_reset();
    model_q = {};
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'h60 + 8'(i);
      if (wrap_ops[i][0] && model_q.size() > 0) void'(model_q.pop_front());
      if (wrap_ops[i][1] && model_q.size() < 3) model_q.push_back(d);
      cycle(wrap_ops[i][1], wrap_ops[i][0], d);
      if (model_q.size() > 0) check($sformatf("wrap%0d_data", i), 32'(do_c), 32'(model_q[0]));
      check($sformatf("wrap%0d_full", i),  32'(fl_c[1]), 32'(model_q.size() == 3));
      check($sformatf("wrap%0d_err", i),   32'(fl_c[0]), 32'h0);
    end

    // Diagnostic: force read pointer to 0 with non-zero pointers.
    apply_reset();
    cycle(1'b1, 1'b0, 8'hD0);
    cycle(1'b1, 1'b0, 8'hD1);
    cycle(1'b1, 1'b0, 8'hD2);
    cycle(1'b0, 1'b1, 8'h00);
    check("diag_pre_err",  32'(fl_a[0]), 32'h0);
    check("diag_pre_data", 32'(do_a), 32'hD1);
    diag_n = 1'b0;
    cycle(1'b0, 1'b0, 8'h00);
    diag_n = 1'b1;
    check("diag_err",    32'(fl_a[0]), 32'h1);
    check("diag_data",   32'(do_a), 32'hD0);
    check("diag_ign_b",  32'(fl_b[0]), 32'h0);
    check("diag_ign_bd", 32'(do_b), 32'hD1);
    cycle(1'b0, 1'b0, 8'h00);
    check("diag_sticky", 32'(fl_a[0]), 32'h1);

    // Reset mid-operation discards contents.
    apply_reset();
    check("midrst_flags", 32'(fl_a), 32'(6'b110000));
    check("midrst_data",  32'(do_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_s1_sf.md
# fifo_s1_sf

Single-clock, synchronous FIFO with static status flags and first-word-fall-through output. It buffers `width`-bit words up to `depth` entries. It provides empty, almost-empty, half-full, almost-full and full flags plus an error flag. The arbiter uses it as its in-flight response-routing queue; it is also a general-purpose building block for shallow request/response bookkeeping.

## Interface
Parameters:
- `width`, default 8: data word width, range 1..256.
- `depth`, default 4: number of storage words, range 2..256.
- `ae_level`, default 1: almost_empty threshold, range 1..depth-1.
- `af_level`, default 1: almost_full threshold, range 1..depth-1.
- `err_mode`, default 0:
  - 0: sticky error, covering overflow, underflow and pointer-consistency failure.
  - 1: sticky error, covering overflow and underflow only.
  - 2: non-sticky error, covering overflow and underflow.
- `rst_mode`, default 0:
  - 0: async reset, memory cleared.
  - 2: async reset, memory not cleared.
  - Any other value is an elaboration error.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `push_req_n` in 1: active-low push request.
- `pop_req_n` in 1: active-low pop request.
- `diag_n` in 1: active-low diagnostic control; tie high in normal use.
- `data_in` in width: write data.
- `empty` out 1: count == 0.
- `almost_empty` out 1: count <= ae_level.
- `half_full` out 1: count >= (depth+1)/2, integer division.
- `almost_full` out 1: count >= depth - af_level.
- `full` out 1: count == depth.
- `error` out 1: overflow, underflow or pointer error, per `err_mode`.
- `data_out` out width: word at the read pointer (head of queue).

## Operation
- State:
  - write pointer and read pointer, each 0..depth-1, wrapping from depth-1 to 0;
  - count, 0..depth, stored as ceil(log2(depth+1)) bits;
  - memory array of depth x width.
- Push (push_req_n=0):
  - If not full: write data_in at the write pointer, increment the write pointer, count+1.
  - If full without a pop: the push is rejected and it is an overflow error; memory, pointers and count are unchanged.
- Pop (pop_req_n=0):
  - If not empty: increment the read pointer, count-1.
  - If empty: it is an underflow error; state is unchanged.
- Simultaneous push and pop:
  - Not empty and not full: both are performed; count unchanged.
  - Full: both are performed (head leaves, new word written); count stays depth; no error.
  - Empty: only the push is performed; count becomes 1; underflow error.
- `data_out` = mem[read pointer], combinational from the pointer; valid whenever !empty.
- Flags are combinational decodes of the registered count; no flag depends on the current-cycle requests.
- `error` behaviour:
  - err_mode 0/1: `error` is set by any overflow or underflow and holds until reset.
  - err_mode 0 only: `error` is also set when (write pointer - read pointer) mod depth != count mod depth.
  - err_mode 2: `error` is registered and reflects only the previous cycle's overflow/underflow.
- `diag_n`: low at a clock edge synchronously forces the read pointer to 0; the write pointer and count are untouched. Under err_mode 0 this trips the pointer check, provided the pointer actually changed. For err_mode 1/2 `diag_n` is ignored.

## Timing
- Reset (rst_n=0), asynchronous and immediate:
  - pointers, count and error go to 0;
  - empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0;
  - rst_mode 0: memory is zeroed and data_out=0;
  - rst_mode 2: memory keeps its contents and data_out is don't-care.
- Reset deassertion is synchronous to clk; the first push may be issued on the first edge after release.
- Latency:
  - A word pushed at edge t appears on data_out, with empty=0, immediately after edge t.
  - A pop at edge t advances data_out after edge t.
- Reset mid-operation discards all contents; flags return to their reset values.

## Structure
- Shared package `fifo_pkg`: the err_mode and rst_mode constants, and a function for the count width (ceil(log2(depth+1))).
- One natural sub-module, `fifo_s1_sf_ctl`: pointers, count, flags, error logic and the memory write enable.
- The top level holds the memory array and the read mux.

## Test plan
- Reset with depth=4, ae_level=1, af_level=3:
  - empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0, data_out=0 (rst_mode 0).
  - Releasing reset changes nothing until the first push.
- Fill and drain with depth=4, width=8: push 0x11, 0x22, 0x33, 0x44.
  - Flags after each push: almost_empty clears at count=2, half_full sets at count=2, almost_full sets at count=1, full sets at count=4.
  - Pops return 0x11..0x44 in order; empty reasserts after the 4th pop.
- Overflow: a 5th push while full without a pop -> error=1 (sticky), count stays 4, data_out stays the head word.
- Underflow: a pop when empty -> error=1, flags unchanged.
  - Under err_mode 2, error returns to 0 one cycle after the request is removed.
- Simultaneous requests:
  - Push+pop when full -> count stays 4, error=0, head advances.
  - Push+pop when empty -> count=1, data_out=data_in, error=1.
- Wrap-around: do 10 push/pop cycles at mixed fill levels with depth=3 -> output order is preserved and error stays 0.
- Diagnostic: with err_mode 0, pointers non-zero and diag_n low for one edge -> error=1 thereafter.
